// File: rtl/microtile_out_monitor_pkg.sv
// mon_pkg: shared constants and types for the microtile uo_out monitor.
//   DEPTH_DEF   - default event FIFO depth (entries, power of two, 2..16)
//   STAMP_W_DEF - default timestamp counter width
//   DATA_W      - width of the observed tile bus
//   PTR_W_DEF   - FIFO pointer width for the default depth
//   entry_t     - FIFO entry layout {data, stamp} at the default stamp width
package mon_pkg;

  localparam int DEPTH_DEF   = 4;
  localparam int STAMP_W_DEF = 8;
  localparam int DATA_W      = 8;
  localparam int PTR_W_DEF   = $clog2(DEPTH_DEF);

  typedef struct packed {
    logic [DATA_W-1:0]      data;
    logic [STAMP_W_DEF-1:0] stamp;
  } entry_t;

  // Pointer width for an arbitrary depth; a depth of 2 still needs one bit.
  function automatic int ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/microtile_out_monitor_if.sv
// Read-side bus of the monitor event FIFO (first-word-fall-through).
//   rd_valid - head entry available          (master -> slave)
//   rd_ready - consumer accepts head entry   (slave  -> master)
//   rd_data  - captured uo value of the head (master -> slave)
//   rd_stamp - timestamp of the head         (master -> slave)
interface microtile_out_monitor_if
  import mon_pkg::*;
#(
  parameter int STAMP_W = STAMP_W_DEF
) ();

  logic               rd_valid;
  logic               rd_ready;
  logic [DATA_W-1:0]  rd_data;
  logic [STAMP_W-1:0] rd_stamp;

  modport master (output rd_valid, output rd_data, output rd_stamp, input rd_ready);
  modport slave  (input rd_valid, input rd_data, input rd_stamp, output rd_ready);

endinterface

// File: rtl/microtile_out_monitor_fifo.sv
// mon_fifo: small first-word-fall-through FIFO.
//   clk, rst   - clock, asynchronous active-high reset
//   push_i     - write wdata_i (accepted when not full, or when popping)
//   pop_i      - drop head entry (ignored when empty)
//   wdata_i    - entry to write
//   rdata_o    - raw head storage (qualify with empty_o / count_o)
//   full_o, empty_o, count_o - occupancy status
module mon_fifo
  import mon_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int W     = DATA_W + STAMP_W_DEF,
  localparam int PW   = ptr_w(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A push into a full FIFO is still taken when the head leaves this cycle.
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: contents are only visible while count is nonzero.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/microtile_out_monitor.sv
// microtile_out_monitor: watches an asynchronous tile uo_out bus, queues each
// change together with a free-running timestamp, and exposes the queue on a
// FWFT read interface.
//   clk, rst - clock, asynchronous active-high reset
//   uo_in    - tile uo_out bus (asynchronous to clk)
//   enable   - 1 = queue change events, 0 = track changes without queueing
//   clr_ovf  - synchronous clear of overflow
//   overflow - sticky: an event was dropped because the FIFO was full
//   rd       - read interface (rd_valid/rd_ready/rd_data/rd_stamp)
module microtile_out_monitor
  import mon_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int STAMP_W = STAMP_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W-1:0]       uo_in,
  input  logic                    enable,
  input  logic                    clr_ovf,
  output logic                    overflow,
  microtile_out_monitor_if.master rd
);

  localparam int CW = $clog2(DEPTH) + 1;

  // Same layout as mon_pkg::entry_t, sized for this instance's stamp width.
  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic [STAMP_W-1:0] stamp;
  } ent_t;

  logic [DATA_W-1:0]  s1_q, s2_q, last_q;
  logic [STAMP_W-1:0] stamp_q, stamp_d;
  logic               ovf_q, ovf_d;

  logic               evt, push, pop, ovf_set;
  logic               fifo_full, fifo_empty;
  logic [CW-1:0]      fifo_cnt;
  ent_t               wr_ent, head;

  // Two-flop synchronizer, change tracker and timestamp counter. last follows
  // s2 unconditionally, so changes seen while disabled are absorbed and do not
  // reappear as events once enable returns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      last_q  <= '0;
      stamp_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      s1_q    <= uo_in;
      s2_q    <= s1_q;
      last_q  <= s2_q;
      stamp_q <= stamp_d;
      ovf_q   <= ovf_d;
    end
  end

  assign stamp_d = stamp_q + STAMP_W'(1);
  assign evt     = (s2_q != last_q);
  assign push    = evt & enable;
  assign pop     = rd.rd_ready & ~fifo_empty;
  assign wr_ent  = '{data: s2_q, stamp: stamp_q};

  // Drop only when full and the head is not leaving in the same cycle;
  // a set beats a simultaneous clear.
  assign ovf_set = push & fifo_full & ~pop;
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_set)      ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
  end
  assign overflow = ovf_q;

  mon_fifo #(
    .DEPTH (DEPTH),
    .W     (DATA_W + STAMP_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wr_ent),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  // Head fields read as zero whenever nothing is queued (including in reset).
  assign rd.rd_valid = ~fifo_empty;
  assign rd.rd_data  = (fifo_cnt != '0) ? head.data  : '0;
  assign rd.rd_stamp = (fifo_cnt != '0) ? head.stamp : '0;

endmodule

// File: tb/tb_microtile_out_monitor.sv
module tb_microtile_out_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] uo_in;
  logic       enable;
  logic       clr_ovf;
  logic       overflow;

  int n_tests = 0;
  int n_fail  = 0;

  microtile_out_monitor_if #(.STAMP_W(8)) rd_if ();

  microtile_out_monitor #(.DEPTH(4), .STAMP_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .uo_in    (uo_in),
    .enable   (enable),
    .clr_ovf  (clr_ovf),
    .overflow (overflow),
    .rd       (rd_if)
  );

  always #5 clk = ~clk;

  // Reference timestamp: 0 in reset, +1 per edge, 8-bit wrap.
  logic [7:0] tb_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) tb_cnt <= 8'h00;
    else     tb_cnt <= tb_cnt + 8'h01;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_one();
    rd_if.rd_ready = 1'b1;
    tick();
    rd_if.rd_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic bad;
    rst = 1'b1; uo_in = 8'h00; enable = 1'b1; clr_ovf = 1'b0; rd_if.rd_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (rd_if.rd_valid !== 1'b0 || rd_if.rd_data !== 8'h00 || rd_if.rd_stamp !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%b data=%h stamp=%h expected 0/00/00",
               rd_if.rd_valid, rd_if.rd_data, rd_if.rd_stamp);
    end
    n_tests++;
    if (overflow !== 1'b0) begin
      n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow);
    end
    rst = 1'b0;
    bad = 1'b0;
    repeat (20) begin
      tick();
      if (rd_if.rd_valid !== 1'b0) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin
      n_fail++; $display("FAIL idle_no_event: rd_valid went 1, expected 0 for 20 cycles");
    end
    n_tests++;
    if (overflow !== 1'b0) begin
      n_fail++; $display("FAIL idle_overflow: got %b expected 0", overflow);
    end
  endtask

  task automatic test_single();
    logic [7:0] exp_st;
    uo_in = 8'h5A;
    exp_st = tb_cnt + 8'd2;
    tick(); tick();
    n_tests++;
    if (rd_if.rd_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_early: rd_valid=%b expected 0 before push edge", rd_if.rd_valid);
    end
    tick();
    n_tests++;
    if (rd_if.rd_valid !== 1'b1 || rd_if.rd_data !== 8'h5A || rd_if.rd_stamp !== exp_st) begin
      n_fail++;
      $display("FAIL single_head: valid=%b data=%h stamp=%h expected 1/5a/%h",
               rd_if.rd_valid, rd_if.rd_data, rd_if.rd_stamp, exp_st);
    end
    pop_one();
    n_tests++;
    if (rd_if.rd_valid !== 1'b0 || rd_if.rd_data !== 8'h00 || rd_if.rd_stamp !== 8'h00) begin
      n_fail++;
      $display("FAIL single_popped: valid=%b data=%h stamp=%h expected 0/00/00",
               rd_if.rd_valid, rd_if.rd_data, rd_if.rd_stamp);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_st [5];
    for (int i = 0; i < 5; i++) begin
      uo_in = 8'(i + 1);
      exp_st[i] = tb_cnt + 8'd2;
      repeat (3) tick();
    end
    tick();
    n_tests++;
    if (overflow !== 1'b1) begin
      n_fail++; $display("FAIL ovf_set: got %b expected 1", overflow);
    end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (rd_if.rd_valid !== 1'b1 || rd_if.rd_data !== 8'(i + 1) || rd_if.rd_stamp !== exp_st[i]) begin
        n_fail++;
        $display("FAIL ovf_entry%0d: valid=%b data=%h stamp=%h expected 1/%h/%h",
                 i, rd_if.rd_valid, rd_if.rd_data, rd_if.rd_stamp, 8'(i + 1), exp_st[i]);
      end
      pop_one();
    end
    n_tests++;
    if (rd_if.rd_valid !== 1'b0 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_drained: valid=%b overflow=%b expected 0/1", rd_if.rd_valid, overflow);
    end
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    n_tests++;
    if (overflow !== 1'b0) begin
      n_fail++; $display("FAIL ovf_clear: got %b expected 0", overflow);
    end
  endtask

  task automatic test_full_pushpop();
    logic [7:0] exp_d [4];
    logic [7:0] st77;
    for (int i = 0; i < 4; i++) begin
      uo_in = 8'h11 + 8'(i);
      repeat (3) tick();
    end
    uo_in = 8'h77;
    st77 = tb_cnt + 8'd2;
    tick(); tick();
    rd_if.rd_ready = 1'b1;
    tick();
    rd_if.rd_ready = 1'b0;
    n_tests++;
    if (dut.u_fifo.count_o !== 3'd4 || overflow !== 1'b0 || rd_if.rd_data !== 8'h12) begin
      n_fail++;
      $display("FAIL full_pushpop: count=%0d overflow=%b head=%h expected 4/0/12",
               dut.u_fifo.count_o, overflow, rd_if.rd_data);
    end
    exp_d[0] = 8'h12; exp_d[1] = 8'h13; exp_d[2] = 8'h14; exp_d[3] = 8'h77;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (rd_if.rd_valid !== 1'b1 || rd_if.rd_data !== exp_d[i]) begin
        n_fail++;
        $display("FAIL full_drain%0d: valid=%b data=%h expected 1/%h",
                 i, rd_if.rd_valid, rd_if.rd_data, exp_d[i]);
      end
      if (i == 3) begin
        n_tests++;
        if (rd_if.rd_stamp !== st77) begin
          n_fail++; $display("FAIL full_stamp77: got %h expected %h", rd_if.rd_stamp, st77);
        end
      end
      pop_one();
    end
    n_tests++;
    if (rd_if.rd_valid !== 1'b0) begin
      n_fail++; $display("FAIL full_empty: rd_valid=%b expected 0", rd_if.rd_valid);
    end
  endtask

  task automatic test_enable();
    logic       bad;
    logic [7:0] st;
    enable = 1'b0;
    uo_in = 8'h10; repeat (4) tick();
    uo_in = 8'h20; repeat (4) tick();
    n_tests++;
    if (rd_if.rd_valid !== 1'b0) begin
      n_fail++; $display("FAIL en_disabled: rd_valid=%b expected 0", rd_if.rd_valid);
    end
    enable = 1'b1;
    bad = 1'b0;
    repeat (5) begin
      tick();
      if (rd_if.rd_valid !== 1'b0) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin
      n_fail++; $display("FAIL en_spurious: rd_valid went 1 after re-enable, expected 0");
    end
    uo_in = 8'h30;
    st = tb_cnt + 8'd2;
    repeat (3) tick();
    n_tests++;
    if (rd_if.rd_valid !== 1'b1 || rd_if.rd_data !== 8'h30 || rd_if.rd_stamp !== st) begin
      n_fail++;
      $display("FAIL en_event: valid=%b data=%h stamp=%h expected 1/30/%h",
               rd_if.rd_valid, rd_if.rd_data, rd_if.rd_stamp, st);
    end
    pop_one();
    n_tests++;
    if (rd_if.rd_valid !== 1'b0) begin
      n_fail++; $display("FAIL en_single: rd_valid=%b expected 0 after one pop", rd_if.rd_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic bad;
    int   guard;
    for (int i = 0; i < 3; i++) begin
      uo_in = 8'h41 + 8'(i);
      repeat (3) tick();
    end
    tick();
    n_tests++;
    if (dut.u_fifo.count_o !== 3'd3) begin
      n_fail++; $display("FAIL rmid_queued: count=%0d expected 3", dut.u_fifo.count_o);
    end
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if (rd_if.rd_valid !== 1'b0 || rd_if.rd_data !== 8'h00 || rd_if.rd_stamp !== 8'h00) begin
      n_fail++;
      $display("FAIL rmid_async: valid=%b data=%h stamp=%h expected 0/00/00",
               rd_if.rd_valid, rd_if.rd_data, rd_if.rd_stamp);
    end
    uo_in = 8'h00;
    repeat (3) tick();
    #3;
    rst = 1'b0;
    bad = 1'b0;
    repeat (5) begin
      tick();
      if (dut.u_fifo.count_o !== 3'd0 || rd_if.rd_valid !== 1'b0) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin
      n_fail++; $display("FAIL rmid_discard: entries present after reset, expected 0");
    end
    guard = 0;
    while (tb_cnt != 8'hFD && guard < 600) begin
      tick();
      guard++;
    end
    n_tests++;
    if (guard >= 600) begin
      n_fail++; $display("FAIL wrap_wait: tb_cnt=%h never reached fd", tb_cnt);
    end
    uo_in = 8'hA1;
    tick();
    uo_in = 8'hA2;
    repeat (3) tick();
    n_tests++;
    if (rd_if.rd_valid !== 1'b1 || rd_if.rd_data !== 8'hA1 || rd_if.rd_stamp !== 8'hFF) begin
      n_fail++;
      $display("FAIL wrap_ff: valid=%b data=%h stamp=%h expected 1/a1/ff",
               rd_if.rd_valid, rd_if.rd_data, rd_if.rd_stamp);
    end
    pop_one();
    n_tests++;
    if (rd_if.rd_valid !== 1'b1 || rd_if.rd_data !== 8'hA2 || rd_if.rd_stamp !== 8'h00) begin
      n_fail++;
      $display("FAIL wrap_00: valid=%b data=%h stamp=%h expected 1/a2/00",
               rd_if.rd_valid, rd_if.rd_data, rd_if.rd_stamp);
    end
    pop_one();
    n_tests++;
    if (rd_if.rd_valid !== 1'b0) begin
      n_fail++; $display("FAIL wrap_empty: rd_valid=%b expected 0", rd_if.rd_valid);
    end
  endtask

  task automatic test_nonzero_after_reset();
    tick();
    rst = 1'b1;
    uo_in = 8'h66;
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
    n_tests++;
    if (rd_if.rd_valid !== 1'b0) begin
      n_fail++; $display("FAIL nz_early: rd_valid=%b expected 0", rd_if.rd_valid);
    end
    tick();
    n_tests++;
    if (rd_if.rd_valid !== 1'b1 || rd_if.rd_data !== 8'h66 || rd_if.rd_stamp !== 8'h02) begin
      n_fail++;
      $display("FAIL nz_event: valid=%b data=%h stamp=%h expected 1/66/02",
               rd_if.rd_valid, rd_if.rd_data, rd_if.rd_stamp);
    end
    pop_one();
    n_tests++;
    if (rd_if.rd_valid !== 1'b0) begin
      n_fail++; $display("FAIL nz_empty: rd_valid=%b expected 0", rd_if.rd_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_full_pushpop();
    test_enable();
    test_reset_mid();
    test_nonzero_after_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/microtile_out_monitor.md
MICROTILE_OUT_MONITOR -- requirements
Module: microtile_out_monitor

Interface
REQ-001 Parameter DEPTH, default 4, event FIFO depth in entries; power of two, 2 to 16.
REQ-002 Parameter STAMP_W, default 8, timestamp counter width in bits.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 uo_in  input  8  tile uo_out bus; asynchronous to clk.
REQ-006 enable  input  1  1 = capture events; 0 = suppress FIFO pushes.
REQ-007 rd_valid  output  1  FIFO head entry available.
REQ-008 rd_ready  input  1  consumer accepts head entry.
REQ-009 rd_data  output  8  captured uo value of head entry.
REQ-010 rd_stamp  output  STAMP_W  timestamp of head entry.
REQ-011 overflow  output  1  sticky; event dropped while FIFO full.
REQ-012 clr_ovf  input  1  synchronous clear of overflow.

Function
REQ-013 uo_in SHALL pass through a two-flop synchronizer (s1, s2) before any use.
REQ-014 Register last SHALL hold the previous s2 value and update to s2 every cycle, regardless of enable or FIFO state.
REQ-015 An event SHALL be s2 != last.
REQ-016 A free-running STAMP_W counter SHALL increment every cycle and wrap from all-ones to 0; it is unaffected by enable.
REQ-017 On an event with enable=1, {s2, counter} SHALL be pushed at that clock edge.
REQ-018 Latency: uo_in stable before edge k -> s1 at k, s2 at k+1, push at k+2 -> rd_valid=1 after edge k+2 (FIFO previously empty).
REQ-019 FIFO SHALL be first-word-fall-through: rd_data/rd_stamp show the head whenever rd_valid=1, and SHALL be 0 when empty.
REQ-020 Pop SHALL occur on an edge with rd_valid=1 and rd_ready=1; rd_ready with the FIFO empty SHALL have no effect.
REQ-021 Push while full, with no pop in the same cycle, SHALL drop the event and set overflow.
REQ-022 Push and pop in the same cycle while full SHALL accept both; count unchanged; no overflow.
REQ-023 Push and pop in the same cycle while holding one entry SHALL leave the new entry at the head, rd_valid staying 1.
REQ-024 Pointers SHALL wrap modulo DEPTH; occupancy SHALL be tracked in a count of width log2(DEPTH)+1.
REQ-025 overflow SHALL remain 1 until clr_ovf=1; if a set and clr_ovf occur in the same cycle, the set SHALL win.
REQ-026 With enable=0, changes SHALL be tracked in last but not pushed, so re-enabling creates no spurious event.

Reset
REQ-027 rst=1 SHALL asynchronously clear s1, s2, last, counter, FIFO pointers/count and overflow to 0.
REQ-028 While rst=1: rd_valid=0, rd_data=0, rd_stamp=0.
REQ-029 Reset mid-operation SHALL discard all queued entries; the first edge after release starts counter at 1.
REQ-030 A nonzero uo_in after reset SHALL produce an event, since last resets to 0.

Structure
REQ-031 Package mon_pkg SHALL hold DEPTH and STAMP_W defaults, the entry typedef {data[7:0], stamp}, and the pointer-width constant.
REQ-032 The FIFO SHALL be one sub-module, mon_fifo (push/pop/full/empty/count, FWFT); synchronizer, change detection, counter and overflow logic live in the top level.

Verification
REQ-033 Reset release, uo_in=0x00 held -> rd_valid stays 0 for 20 cycles; overflow=0.
REQ-034 uo_in 0x00->0x5A before edge k, rd_ready=0 -> rd_valid=1 after edge k+2 with rd_data=0x5A and rd_stamp=counter at that push; one pop then gives rd_valid=0.
REQ-035 Five changes (0x01,0x02,0x03,0x04,0x05) spaced 3 cycles apart, rd_ready=0, DEPTH=4 -> four entries 0x01..0x04 in order, overflow=1; clr_ovf pulse -> overflow=0.
REQ-036 FIFO full with rd_ready=1 on the cycle of a push of 0x77 -> count stays 4, overflow=0, and 0x77 is the last entry drained.
REQ-037 enable=0, uo_in 0x10->0x20, then enable=1 with no further change -> no entry; a later change to 0x30 -> one entry 0x30.
REQ-038 rst asserted with 3 entries queued, not aligned to clk -> rd_valid=0 immediately; after release, 0 entries; an 8-bit stamp wraps 0xFF->0x00 across consecutive events.
